// File: rtl/mul1_feeder.sv
// mul1_feeder: job sequencer in front of the repeated-addition multiplier.
// Ports: in_* operand stream, mul_* multiplier handshake/bus, out_* result stream,
//   err sticky timeout flag, level FIFO occupancy. Async active-high reset.
module mul1_feeder #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     mul_rst,
   output logic                     mul_start,
   output logic [WIDTH-1:0]         mul_data,
   input  logic                     mul_ldA,
   input  logic                     mul_ldB,
   input  logic                     mul_done,
   input  logic [WIDTH-1:0]         mul_prod,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_prod,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LIM  = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, CLR, GO, RUN, CAPTURE, BYPASS
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW:0]       level_q, level_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_prod_q, out_prod_d;
   logic              err_q, err_d;
   logic              mul_rst_q, mul_rst_d;
   logic [WIDTH-1:0]  fifo_a_q [DEPTH];
   logic [WIDTH-1:0]  fifo_b_q [DEPTH];

   logic              push, pop;
   logic [AW-1:0]     rd_nx;
   logic [WIDTH-1:0]  head_a, head_b;
   logic              head_zero, next_zero;

   assign in_ready  = (level_q < FULL);
   assign push      = in_valid & in_ready;
   assign rd_nx     = rd_q + AW'(1);
   assign head_a    = fifo_a_q[rd_q];
   assign head_b    = fifo_b_q[rd_q];
   assign head_zero = (head_a == '0) || (head_b == '0);
   // Pair behind the head: used to avoid chaining a zero operand
   // straight into CLR after an abort.
   assign next_zero = (fifo_a_q[rd_nx] == '0) || (fifo_b_q[rd_nx] == '0);

   assign mul_data  = (level_q == '0) ? '0 : (mul_ldB ? head_b : head_a);
   assign mul_rst   = mul_rst_q;
   assign out_valid = out_valid_q;
   assign out_prod  = out_prod_q;
   assign err       = err_q;
   assign level     = level_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      mul_start   = 1'b0;
      out_valid_d = out_valid_q & ~out_ready;
      out_prod_d  = out_prod_q;
      err_d       = err_q;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0 && !out_valid_q)
               state_d = head_zero ? BYPASS : CLR;
         end
         CLR: begin
            cnt_d   = '0;
            state_d = GO;
         end
         GO: begin
            mul_start = 1'b1;
            if (mul_ldA) state_d = RUN;
         end
         RUN: begin
            if (mul_done) begin
               state_d = CAPTURE;
            end else if (cnt_q == LIM) begin
               err_d = 1'b1;
               pop   = 1'b1;
               if (level_q > (AW + 1)'(1) && !next_zero)
                  state_d = CLR;
               else
                  state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CAPTURE: begin
            out_prod_d  = mul_prod;
            out_valid_d = 1'b1;
            pop         = 1'b1;
            state_d     = IDLE;
         end
         BYPASS: begin
            out_prod_d  = '0;
            out_valid_d = 1'b1;
            pop         = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      mul_rst_d = (state_d == CLR);
   end

   always_comb begin
      rd_d    = pop  ? rd_nx : rd_q;
      wr_d    = push ? wr_q + AW'(1) : wr_q;
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rd_q        <= '0;
         wr_q        <= '0;
         level_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_prod_q  <= '0;
         err_q       <= 1'b0;
         mul_rst_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         level_q     <= level_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_prod_q  <= out_prod_d;
         err_q       <= err_d;
         mul_rst_q   <= mul_rst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a_q[wr_q] <= in_a;
         fifo_b_q[wr_q] <= in_b;
      end
   end

endmodule
